// File: rtl/e_mdu.sv
// ============================================================================
// Module      : e_mdu
// Description : E-stage multiply/divide unit owning HI/LO, with a busy counter
//               that models multi-cycle mult/div latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    input  logic        Req,
    input  logic [31:0] RD1,
    input  logic [31:0] RD2,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] Out
);

    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MFHI  = 4'd5;
    localparam logic [3:0] c_OP_MFLO  = 4'd6;
    localparam logic [3:0] c_OP_MTHI  = 4'd7;
    localparam logic [3:0] c_OP_MTLO  = 4'd8;

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CW         = $clog2(c_MAX_CYCLES + 1);

    logic [c_CW-1:0] r_cnt;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;
    logic [31:0]     r_pend_hi;
    logic [31:0]     r_pend_lo;
    logic            r_pend_wr;

    logic        w_accept;
    logic        w_msgn;
    logic [63:0] w_prod;
    logic        w_dsgn;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_dvs_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q;
    logic [31:0] w_r;

    assign w_accept = Start && !Req && (r_cnt == '0);

    assign w_msgn = (MDUOp == c_OP_MULT);
    assign w_prod = w_msgn ? ({{32{RD1[31]}}, RD1} * {{32{RD2[31]}}, RD2})
                           : ({32'd0, RD1} * {32'd0, RD2});

    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    assign w_dsgn     = (MDUOp == c_OP_DIV);
    assign w_dvd      = (w_dsgn && RD1[31]) ? (~RD1 + 32'd1) : RD1;
    assign w_dvs      = (w_dsgn && RD2[31]) ? (~RD2 + 32'd1) : RD2;
    assign w_dvs_safe = (RD2 == 32'd0) ? 32'd1 : w_dvs;
    assign w_q_mag    = w_dvd / w_dvs_safe;
    assign w_r_mag    = w_dvd % w_dvs_safe;
    assign w_q        = (w_dsgn && (RD1[31] ^ RD2[31])) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_r        = (w_dsgn && RD1[31]) ? (~w_r_mag + 32'd1) : w_r_mag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_CW'(1);
            if (r_cnt == c_CW'(1) && r_pend_wr) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
        end else if (w_accept) begin
            case (MDUOp)
                c_OP_MULT, c_OP_MULTU: begin
                    r_pend_hi <= w_prod[63:32];
                    r_pend_lo <= w_prod[31:0];
                    r_pend_wr <= 1'b1;
                    r_cnt     <= c_CW'(MULT_CYCLES);
                end
                c_OP_DIV, c_OP_DIVU: begin
                    r_pend_hi <= w_r;
                    r_pend_lo <= w_q;
                    r_pend_wr <= (RD2 != 32'd0);
                    r_cnt     <= c_CW'(DIV_CYCLES);
                end
                c_OP_MTHI: r_hi <= RD1;
                c_OP_MTLO: r_lo <= RD1;
                default: ;
            endcase
        end
    end

    assign Busy = (r_cnt != '0);
    assign HI   = r_hi;
    assign LO   = r_lo;

    always_comb begin
        Out = 32'd0;
        if (MDUOp == c_OP_MFHI)
            Out = r_hi;
        else if (MDUOp == c_OP_MFLO)
            Out = r_lo;
    end

endmodule

`default_nettype wire

// File: tb/tb_e_mdu.sv
// ============================================================================
// Module      : tb_e_mdu
// Description : Self-checking bench for e_mdu with a HI/LO result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  MDUOp;
    logic        Start;
    logic        Req;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] Out;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [63:0] sb_q[$];

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .MDUOp(MDUOp), .Start(Start), .Req(Req),
        .RD1(RD1), .RD2(RD2), .Busy(Busy), .HI(HI), .LO(LO), .Out(Out)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference result as {hi, lo}, computed with wide native arithmetic.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] cur);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            4'd1: return 64'(sa * sb);
            4'd2: return ua * ub;
            4'd3: begin
                if (b == 32'd0) return cur;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 32'd0) return cur;
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            default: return cur;
        endcase
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic req);
        logic acc;
        acc   = !req && !Busy;
        MDUOp = op;
        RD1   = a;
        RD2   = b;
        Req   = req;
        Start = 1'b1;
        if (acc && op >= 4'd1 && op <= 4'd4) sb_q.push_back(model(op, a, b, {m_hi, m_lo}));
        if (acc && op == 4'd7) m_hi = a;
        if (acc && op == 4'd8) m_lo = a;
        cyc();
        Start = 1'b0;
        Req   = 1'b0;
        MDUOp = 4'd0;
    endtask

    task automatic wait_busy(output int n, output bit stable);
        logic [31:0] h0, l0;
        h0 = HI;
        l0 = LO;
        n = 0;
        stable = 1'b1;
        while (Busy && n < 100) begin
            n++;
            if (HI !== h0 || LO !== l0) stable = 1'b0;
            cyc();
        end
    endtask

    task automatic retire(output logic [63:0] exp, output bit ok);
        ok  = (sb_q.size() != 0);
        exp = 64'd0;
        if (ok) begin
            exp  = sb_q.pop_front();
            m_hi = exp[63:32];
            m_lo = exp[31:0];
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; Start = 1'b0; Req = 1'b0; MDUOp = 4'd0; RD1 = '0; RD2 = '0;
        cyc(); cyc();
        reset = 1'b0;
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        n_cmp++; if (HI !== 32'd0) begin n_err++; $display("FAIL reset_hi got=%h exp=0", HI); end
        n_cmp++; if (LO !== 32'd0) begin n_err++; $display("FAIL reset_lo got=%h exp=0", LO); end
    endtask

    task automatic test_mult();
        int n; bit st, ok; logic [63:0] e;
        issue(4'd1, 32'hFFFFFFFD, 32'd5, 1'b0);
        wait_busy(n, st);
        retire(e, ok);
        n_cmp++; if (n != 5) begin n_err++; $display("FAIL mult_busy_cycles got=%0d exp=5", n); end
        n_cmp++; if (!st) begin n_err++; $display("FAIL mult_hilo_stable got=changed exp=unchanged"); end
        n_cmp++; if (!ok || HI !== e[63:32]) begin n_err++; $display("FAIL mult_hi got=%h exp=%h", HI, e[63:32]); end
        n_cmp++; if (!ok || LO !== e[31:0]) begin n_err++; $display("FAIL mult_lo got=%h exp=%h", LO, e[31:0]); end
        MDUOp = 4'd5; #1;
        n_cmp++; if (Out !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mfhi_out got=%h exp=ffffffff", Out); end
        MDUOp = 4'd6; #1;
        n_cmp++; if (Out !== 32'hFFFFFFF1) begin n_err++; $display("FAIL mflo_out got=%h exp=fffffff1", Out); end
        MDUOp = 4'd0; #1;
        n_cmp++; if (Out !== 32'd0) begin n_err++; $display("FAIL none_out got=%h exp=0", Out); end
    endtask

    task automatic test_back_to_back();
        int n; bit st, ok; logic [63:0] e;
        issue(4'd4, 32'd7, 32'd2, 1'b0);
        wait_busy(n, st);
        retire(e, ok);
        n_cmp++; if (n != 10) begin n_err++; $display("FAIL divu_busy_cycles got=%0d exp=10", n); end
        n_cmp++; if (!st) begin n_err++; $display("FAIL divu_hilo_stable got=changed exp=unchanged"); end
        n_cmp++; if (!ok || HI !== e[63:32] || LO !== e[31:0])
            begin n_err++; $display("FAIL divu_hilo got=%h_%h exp=%h_%h", HI, LO, e[63:32], e[31:0]); end
        issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        wait_busy(n, st);
        retire(e, ok);
        n_cmp++; if (n != 10) begin n_err++; $display("FAIL div_b2b_busy_cycles got=%0d exp=10", n); end
        n_cmp++; if (!ok || HI !== e[63:32] || LO !== e[31:0])
            begin n_err++; $display("FAIL div_neg_hilo got=%h_%h exp=%h_%h", HI, LO, e[63:32], e[31:0]); end
    endtask

    task automatic test_cancel();
        issue(4'd7, 32'h12345678, 32'd0, 1'b1);
        n_cmp++; if (HI !== m_hi) begin n_err++; $display("FAIL mthi_cancel got=%h exp=%h", HI, m_hi); end
        issue(4'd1, 32'd3, 32'd4, 1'b1);
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL mult_cancel_busy got=%b exp=0", Busy); end
        cyc(); cyc(); cyc(); cyc(); cyc(); cyc();
        n_cmp++; if (HI !== m_hi || LO !== m_lo)
            begin n_err++; $display("FAIL mult_cancel_hilo got=%h_%h exp=%h_%h", HI, LO, m_hi, m_lo); end
        issue(4'd8, 32'h0000ABCD, 32'd0, 1'b0);
        n_cmp++; if (LO !== 32'h0000ABCD) begin n_err++; $display("FAIL mtlo got=%h exp=0000abcd", LO); end
    endtask

    task automatic test_reset_mid_op();
        int n; bit st;
        issue(4'd7, 32'h11111111, 32'd0, 1'b0);
        issue(4'd8, 32'h11111111, 32'd0, 1'b0);
        n_cmp++; if (HI !== 32'h11111111 || LO !== 32'h11111111)
            begin n_err++; $display("FAIL mthi_mtlo got=%h_%h exp=11111111_11111111", HI, LO); end
        issue(4'd3, 32'd100, 32'd7, 1'b0);
        cyc(); cyc(); cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        sb_q.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        n_cmp++; if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
            begin n_err++; $display("FAIL reset_mid_op got=busy%b %h_%h exp=busy0 0_0", Busy, HI, LO); end
        wait_busy(n, st);
        for (int i = 0; i < 12; i++) cyc();
        n_cmp++; if (HI !== 32'd0 || LO !== 32'd0)
            begin n_err++; $display("FAIL reset_no_late_update got=%h_%h exp=0_0", HI, LO); end
    endtask

    task automatic test_busy_req();
        int n; bit st, ok; logic [63:0] e;
        issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        MDUOp = 4'd1; RD1 = 32'd2; RD2 = 32'd3; Start = 1'b1; Req = 1'b1;
        cyc();
        Req = 1'b0;
        cyc();
        Start = 1'b0; MDUOp = 4'd0;
        wait_busy(n, st);
        retire(e, ok);
        n_cmp++; if (n + 2 != 5) begin n_err++; $display("FAIL multu_busy_cycles got=%0d exp=5", n + 2); end
        n_cmp++; if (!ok || HI !== e[63:32] || LO !== e[31:0])
            begin n_err++; $display("FAIL multu_hilo got=%h_%h exp=%h_%h", HI, LO, e[63:32], e[31:0]); end
        cyc(); cyc(); cyc(); cyc(); cyc(); cyc();
        n_cmp++; if (Busy !== 1'b0 || HI !== 32'hFFFFFFFE || LO !== 32'h00000001)
            begin n_err++; $display("FAIL ignored_op_effect got=busy%b %h_%h exp=busy0 fffffffe_00000001", Busy, HI, LO); end
    endtask

    task automatic test_div_edges();
        int n; bit st, ok; logic [63:0] e;
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        wait_busy(n, st);
        retire(e, ok);
        n_cmp++; if (!ok || HI !== e[63:32] || LO !== e[31:0])
            begin n_err++; $display("FAIL div_overflow got=%h_%h exp=%h_%h", HI, LO, e[63:32], e[31:0]); end
        issue(4'd4, 32'd1234, 32'd0, 1'b0);
        wait_busy(n, st);
        retire(e, ok);
        n_cmp++; if (n != 10) begin n_err++; $display("FAIL divu0_busy_cycles got=%0d exp=10", n); end
        n_cmp++; if (!ok || HI !== e[63:32] || LO !== e[31:0])
            begin n_err++; $display("FAIL divu0_hilo got=%h_%h exp=%h_%h", HI, LO, e[63:32], e[31:0]); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_back_to_back();
        test_cancel();
        test_reset_mid_op();
        test_busy_req();
        test_div_edges();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
